// File: rtl/adder_share_ctrl.sv
// Two-way round-robin front end for one shared ripple adder: latches the granted operands,
// waits SETTLE_CYCLES for the adder to settle, then captures {co,sum} and pulses ack.
module adder_share_ctrl #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             _MR,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             ci0,
  input  logic             ci1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_co,
  output logic             busy,
  output logic [1:0]       grant,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_co
);

  // A zero settle time would sample the adder in the same cycle its inputs change.
  localparam int unsigned SettleEff = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned CntW      = $clog2(SettleEff + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [1:0]        grant_q, grant_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              ci_q, ci_d, co_q, co_d;
  logic              pick1;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    ci_d    = ci_q;
    sum_d   = sum_q;
    co_d    = co_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          a_d     = pick1 ? a1 : a0;
          b_d     = pick1 ? b1 : b0;
          ci_d    = pick1 ? ci1 : ci0;
          cnt_d   = CntW'(SettleEff);
          state_d = StSettle;
        end
      end
      StSettle: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          sum_d   = add_sum;
          co_d    = add_co;
          last_d  = grant_q[1];
          state_d = StDone;
        end
      end
      StDone: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge _MR) begin
    if (!_MR) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign ack0    = (state_q == StDone) & grant_q[0];
  assign ack1    = (state_q == StDone) & grant_q[1];
  assign busy    = (state_q != StIdle);
  assign grant   = grant_q;
  assign add_a   = a_q;
  assign add_b   = b_q;
  assign add_ci  = ci_q;
  assign res_sum = sum_q;
  assign res_co  = co_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: main instance with a 12 ns adder and SETTLE_CYCLES=2, plus a
// SETTLE_CYCLES=1 instance showing a too-short settle window captures the previous sum.
module tb_adder_share_ctrl;

  localparam int W = 4;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         co;
  } exp_t;

  logic clk = 1'b0;
  logic mr_n;

  // Main instance (SETTLE_CYCLES=2)
  logic         req0, req1, ci0, ci1, ack0, ack1, res_co, busy, add_ci, add_co;
  logic [W-1:0] a0, b0, a1, b1, res_sum, add_a, add_b, add_sum;
  logic [1:0]   grant;

  // Short-settle instance (SETTLE_CYCLES=1)
  logic         s_req0, s_req1, s_ci0, s_ci1, s_ack0, s_ack1, s_res_co, s_busy, s_add_ci, s_add_co;
  logic [W-1:0] s_a0, s_b0, s_a1, s_b1, s_res_sum, s_add_a, s_add_b, s_add_sum;
  logic [1:0]   s_grant;

  exp_t sb[$];
  exp_t sb_s[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign #12 {add_co, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};
  assign #12 {s_add_co, s_add_sum} = {1'b0, s_add_a} + {1'b0, s_add_b} + {{W{1'b0}}, s_add_ci};

  adder_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
    .clk(clk), ._MR(mr_n), .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ci0(ci0), .ci1(ci1), .ack0(ack0), .ack1(ack1), .res_sum(res_sum), .res_co(res_co),
    .busy(busy), .grant(grant), .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_sum(add_sum), .add_co(add_co)
  );

  adder_share_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut_short (
    .clk(clk), ._MR(mr_n), .req0(s_req0), .req1(s_req1), .a0(s_a0), .b0(s_b0), .a1(s_a1),
    .b1(s_b1), .ci0(s_ci0), .ci1(s_ci1), .ack0(s_ack0), .ack1(s_ack1), .res_sum(s_res_sum),
    .res_co(s_res_co), .busy(s_busy), .grant(s_grant), .add_a(s_add_a), .add_b(s_add_b),
    .add_ci(s_add_ci), .add_sum(s_add_sum), .add_co(s_add_co)
  );

  // Every ack of the main instance must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: got ack1/ack0=%b%b, required no ack", ack1, ack0);
      end else begin
        e = sb.pop_front();
        if ({ack1, ack0} !== (e.id ? 2'b10 : 2'b01) || res_sum !== e.sum || res_co !== e.co) begin
          failures++;
          $display("FAIL result: got ack=%b%b sum=%0d co=%b, required id=%0d sum=%0d co=%b",
                   ack1, ack0, res_sum, res_co, e.id, e.sum, e.co);
        end
      end
    end
  end

  task automatic test_reset();
    mr_n = 1'b0;
    req0 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, busy, ack0, ack1} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got grant=%b busy=%b ack=%b%b, required all 0",
               grant, busy, ack1, ack0);
    end
    checks++;
    if ({add_a, add_b, add_ci, res_sum, res_co} !== '0) begin
      failures++;
      $display("FAIL reset_data: got a=%0d b=%0d ci=%b sum=%0d co=%b, required all 0",
               add_a, add_b, add_ci, res_sum, res_co);
    end
    // Release with req0 held: grant at first edge, then abort mid-SETTLE.
    a0 = 4'd7; b0 = 4'd4;
    mr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1 || add_a !== 4'd7) begin
      failures++;
      $display("FAIL first_grant: got grant=%b busy=%b add_a=%0d, required 01 1 7",
               grant, busy, add_a);
    end
    mr_n = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || add_a !== 4'd0) begin
      failures++;
      $display("FAIL async_reset: got grant=%b busy=%b add_a=%0d, required 00 0 0",
               grant, busy, add_a);
    end
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (res_sum !== 4'd0 || res_co !== 1'b0) begin
      failures++;
      $display("FAIL abort_result: got sum=%0d co=%b, required 0 0", res_sum, res_co);
    end
    mr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_op();
    a0 = 4'd1; b0 = 4'd2; ci0 = 1'b0; req0 = 1'b1;
    sb.push_back('{id: 1'b0, sum: 4'd3, co: 1'b0});
    @(negedge clk);  // after E0
    req0 = 1'b0;
    checks++;
    if (add_a !== 4'd1 || add_b !== 4'd2 || add_ci !== 1'b0 || grant !== 2'b01 || ack0 !== 1'b0)
    begin
      failures++;
      $display("FAIL single_e0: got a=%0d b=%0d ci=%b grant=%b ack0=%b, required 1 2 0 01 0",
               add_a, add_b, add_ci, grant, ack0);
    end
    @(negedge clk);  // after E1
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_e1: got ack0=%b busy=%b, required 0 1", ack0, busy);
    end
    @(negedge clk);  // after E2
    checks++;
    if (ack0 !== 1'b1) begin
      failures++;
      $display("FAIL single_ack_rise: got ack0=%b, required 1", ack0);
    end
    @(negedge clk);  // after E3
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b0 || grant !== 2'b00 || add_a !== 4'd1 || res_sum !== 4'd3)
    begin
      failures++;
      $display("FAIL single_e3: got ack0=%b busy=%b grant=%b add_a=%0d sum=%0d, required 0 0 00 1 3",
               ack0, busy, grant, add_a, res_sum);
    end
  endtask

  task automatic test_carry_wrap();
    a1 = 4'd15; b1 = 4'd1; ci1 = 1'b1; req1 = 1'b1;
    sb.push_back('{id: 1'b1, sum: 4'd1, co: 1'b1});
    @(negedge clk);
    req1 = 1'b0;
    checks++;
    if (grant !== 2'b10 || add_ci !== 1'b1) begin
      failures++;
      $display("FAIL carry_grant: got grant=%b ci=%b, required 10 1", grant, add_ci);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ack1 !== 1'b1 || grant !== 2'b10) begin
      failures++;
      $display("FAIL carry_ack: got ack1=%b grant=%b, required 1 10", ack1, grant);
    end
    @(negedge clk);
  endtask

  task automatic test_tie_arbitration();
    int ack_cyc[$];
    int cyc = 0;
    a0 = 4'd3; b0 = 4'd4; ci0 = 1'b0;
    a1 = 4'd8; b1 = 4'd9; ci1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{id: 1'b0, sum: 4'd7, co: 1'b0});
      sb.push_back('{id: 1'b1, sum: 4'd1, co: 1'b1});
    end
    req0 = 1'b1; req1 = 1'b1;
    while (ack_cyc.size() < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) ack_cyc.push_back(cyc);
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (ack_cyc.size() != 4) begin
      failures++;
      $display("FAIL tie_count: got %0d acks within 40 cycles, required 4", ack_cyc.size());
    end
    for (int i = 1; i < ack_cyc.size(); i++) begin
      checks++;
      if (ack_cyc[i] - ack_cyc[i-1] != 4) begin
        failures++;
        $display("FAIL tie_spacing: got %0d cycles between acks, required 4",
                 ack_cyc[i] - ack_cyc[i-1]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_operand_isolation();
    a0 = 4'd2; b0 = 4'd1; ci0 = 1'b0; req0 = 1'b1;
    sb.push_back('{id: 1'b0, sum: 4'd3, co: 1'b0});
    @(negedge clk);  // after E0
    req0 = 1'b0;
    @(negedge clk);  // after E1
    a0 = 4'd9;
    checks++;
    if (add_a !== 4'd2) begin
      failures++;
      $display("FAIL isolation_mid: got add_a=%0d, required 2", add_a);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (add_a !== 4'd2 || res_sum !== 4'd3) begin
      failures++;
      $display("FAIL isolation_end: got add_a=%0d sum=%0d, required 2 3", add_a, res_sum);
    end
  endtask

  task automatic test_settle_violation();
    logic [W-1:0] settled = 4'd0;  // adder output settled before each grant
    logic [W-1:0] ops_a[2];
    logic [W-1:0] ops_b[2];
    exp_t e;
    ops_a[0] = 4'd1; ops_b[0] = 4'd2;
    ops_a[1] = 4'd5; ops_b[1] = 4'd6;
    for (int i = 0; i < 2; i++) begin
      s_a0 = ops_a[i]; s_b0 = ops_b[i]; s_ci0 = 1'b0; s_req0 = 1'b1;
      sb_s.push_back('{id: 1'b0, sum: settled, co: 1'b0});
      settled = ops_a[i] + ops_b[i];
      @(negedge clk);  // after E0
      s_req0 = 1'b0;
      @(negedge clk);  // after E1: capture with SETTLE_CYCLES=1
      e = sb_s.pop_front();
      checks++;
      if (s_ack0 !== 1'b1 || s_res_sum !== e.sum) begin
        failures++;
        $display("FAIL settle_violation op%0d: got ack0=%b sum=%0d, required 1 %0d (stale)",
                 i, s_ack0, s_res_sum, e.sum);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    {req1, ci0, ci1} = '0;
    {a0, b0, a1, b1} = '0;
    {s_req0, s_req1, s_ci0, s_ci1} = '0;
    {s_a0, s_b0, s_a1, s_b1} = '0;
    test_reset();
    test_single_op();
    test_carry_wrap();
    test_tie_arbitration();
    test_operand_isolation();
    test_settle_violation();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL missing_acks: got %0d outstanding results, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Sequencer and two-way arbiter for a single shared WIDTH-bit ripple adder with real propagation delay. It accepts add requests from two requesters and grants one at a time, round-robin on ties. It latches the granted operands onto the adder inputs and holds them for a fixed number of settle cycles before capturing {co,sum}. The result is then returned with a one-cycle ack. It sits between the control/sequencing logic and the shared adder. It guarantees the adder output is never sampled before it has settled.

## Interface
- WIDTH, 4: operand and sum width.
- SETTLE_CYCLES, 2: clock cycles the adder inputs are held stable before capture. Must be ≥1; a value of 0 is treated as 1. Set it so SETTLE_CYCLES × clock period exceeds the adder propagation delay.

- clk  in  1  single clock; all state changes on the rising edge.
- _MR  in  1  master reset, asynchronous, active-low.
- req0, req1  in  1  add request from requester 0 / 1; level, held until ack.
- a0, b0, a1, b1  in  WIDTH  operands for each requester.
- ci0, ci1  in  1  carry-in for each requester.
- ack0, ack1  out  1  one-cycle pulse: the result for that requester is valid.
- res_sum  out  WIDTH  captured sum; held until the next capture.
- res_co  out  1  captured carry-out; held until the next capture.
- busy  out  1  high in SETTLE and DONE.
- grant  out  2  one-hot current owner ({req1,req0} order); 0 when idle.
- add_a, add_b  out  WIDTH  registered operands driving the shared adder.
- add_ci  out  1  registered carry-in driving the shared adder.
- add_sum  in  WIDTH  sum from the shared adder.
- add_co  in  1  carry-out from the shared adder.

## Operation
- States: IDLE, SETTLE, DONE.
- Registers: state, settle counter (width $clog2(SETTLE_CYCLES+1)), last-served flag `last`, operand registers, result registers.
- **IDLE**
  - Samples req0/req1 at each edge.
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requesting: grant the requester not equal to `last`.
  - On grant:
    - latch that requester's a/b/ci into add_a/add_b/add_ci;
    - set grant one-hot and busy=1;
    - load counter = SETTLE_CYCLES;
    - go to SETTLE.
- **SETTLE**
  - Counter decrements each edge.
  - At the edge where counter == 1:
    - capture add_sum/add_co into res_sum/res_co;
    - assert ack for the granted requester;
    - update `last` to that requester;
    - go to DONE.
- **DONE**
  - ack is high for this one cycle.
  - Next edge: ack=0, grant=0, busy=0, go to IDLE.
  - add_a/add_b/add_ci keep their values until the next grant.
- Operands are sampled only at the grant edge. Requester operand changes after grant do not affect the result.
- A requester must drop req before the first IDLE sampling edge after its ack. If req is still high there, it is a new request.
- Arithmetic is performed by the external adder only. The block does not compute or check the sum: res = {add_co, add_sum} exactly as sampled.
- `last` resets to requester 1, so requester 0 wins the first tie.

## Timing
- Reset (_MR low, asynchronous, immediate) values:
  - state=IDLE, counter=0, `last`=1;
  - ack0=ack1=0, grant=0, busy=0;
  - add_a=add_b=0, add_ci=0;
  - res_sum=0, res_co=0.
- Release of _MR is synchronous to the next clk edge. The first grant is possible at the first edge after release.
- Latency, with grant edge E0:
  - adder inputs are valid from E0;
  - capture and ack rise at E(SETTLE_CYCLES);
  - ack falls at E(SETTLE_CYCLES+1).
- Back-to-back issue: the next grant is at E(SETTLE_CYCLES+2) at the earliest. Throughput is one op per SETTLE_CYCLES+2 cycles.
- Requests arriving during SETTLE/DONE are not sampled. They wait, and are arbitrated at the next IDLE edge.
- Reset mid-SETTLE or mid-DONE:
  - the operation is aborted;
  - no ack is issued;
  - all outputs take their reset values;
  - the pending requester must re-request (its held req is re-sampled after release).
- The adder must settle within SETTLE_CYCLES × period − setup. If it has not, a stale value is captured; the block does not detect this.

## Test plan
- **Reset:** hold _MR low, toggle clk, drive req0=1 → all outputs 0 and no grant. Assert _MR low mid-SETTLE (SETTLE_CYCLES=2) → ack never pulses, res_sum=0.
- **Single op:** req0, a0=1, b0=2, ci0=0; adder modelled with #12 delay, 10 ns clk, SETTLE_CYCLES=2 → add_a=1, add_b=2 from E0; ack0 high only in cycle E2–E3; res_sum=3, res_co=0.
- **Carry/wrap:** req1, a1=15, b1=1, ci1=1 → ack1 pulse; res_sum=1, res_co=1; grant=2'b10 during the op.
- **Tie arbitration:** req0 and req1 both high from reset and held after ack → service order 0,1,0,1; each ack is SETTLE_CYCLES+2 cycles apart.
- **Operand isolation:** grant req0 (a0=2, b0=1); change a0 to 9 one cycle after grant → res_sum=3, add_a stays 2.
- **Settle violation characterisation:** SETTLE_CYCLES=1 with the 12 ns adder and 10 ns clock → captured res_sum equals the previous adder output, not the new sum. This confirms the parameter must cover the propagation delay.
